// File: rtl/key_code_decoder.sv
// Key code decoder: stability filter, key-line decode and press/release event buffer
// for the 9-key active-low priority code.
module key_code_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code_n,
  output logic [8:0] line_n,
  output logic [3:0] key_val,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [3:0] evt_key,
  output logic       evt_press,
  output logic       evt_overrun,
  output logic       code_err
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINE_W = 9;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0]  STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CODE_W-1:0] MAX_KEY    = CODE_W'(9);
  localparam logic [LINE_W-1:0] LINE_NONE  = '1;

  typedef enum logic {IDLE, HELD} state_t;

  state_t              state;
  logic [CODE_W-1:0]   candidate;
  logic [CNT_W-1:0]    count;
  logic [CODE_W-1:0]   last_stable;

  logic [CODE_W-1:0]   raw_c;
  logic [CNT_W-1:0]    cnt_next_c;
  logic                stable_new_c;
  logic                is_key_c;
  logic                new_evt_c;
  logic [CODE_W-1:0]   new_key_c;
  logic                new_press_c;
  logic                handshake_c;

  // Active-low one-hot line pattern for key k (1..9)
  function automatic logic [LINE_W-1:0] key_lines(input logic [CODE_W-1:0] k);
    key_lines = ~(LINE_W'(1) << (CODE_W'(k - CODE_W'(1))));
  endfunction

  // Filter next count, new-stable detection and event generation
  always_comb begin
    raw_c        = ~code_n;
    cnt_next_c   = CNT_W'(1);
    stable_new_c = 1'b0;
    is_key_c     = 1'b0;
    new_evt_c    = 1'b0;
    new_key_c    = '0;
    new_press_c  = 1'b0;
    handshake_c  = evt_valid && evt_ready;

    if (raw_c == candidate) begin
      cnt_next_c = (count >= STABLE_CNT) ? STABLE_CNT : CNT_W'(count + CNT_W'(1));
    end
    stable_new_c = (cnt_next_c == STABLE_CNT) && (raw_c != last_stable);
    is_key_c     = (raw_c != '0) && (raw_c <= MAX_KEY);

    if (stable_new_c) begin
      if (is_key_c) begin
        new_evt_c   = 1'b1;
        new_key_c   = raw_c;
        new_press_c = 1'b1;
      end else if (raw_c == '0 && state == HELD) begin
        new_evt_c   = 1'b1;
        new_key_c   = key_val;
        new_press_c = 1'b0;
      end
    end
  end

  // Filter state, key FSM, held-key outputs and single-entry event buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      candidate   <= '0;
      count       <= '0;
      last_stable <= '0;
      line_n      <= LINE_NONE;
      key_val     <= '0;
      evt_valid   <= 1'b0;
      evt_key     <= '0;
      evt_press   <= 1'b0;
      evt_overrun <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      candidate <= raw_c;
      count     <= cnt_next_c;
      code_err  <= 1'b0;

      if (stable_new_c) begin
        last_stable <= raw_c;
        if (is_key_c) begin
          state   <= HELD;
          line_n  <= key_lines(raw_c);
          key_val <= raw_c;
        end else if (raw_c == '0) begin
          state   <= IDLE;
          line_n  <= LINE_NONE;
          key_val <= '0;
        end else begin
          code_err <= 1'b1;
        end
      end

      if (new_evt_c) begin
        if (!evt_valid || handshake_c) begin
          evt_valid <= 1'b1;
          evt_key   <= new_key_c;
          evt_press <= new_press_c;
        end else begin
          evt_overrun <= 1'b1;
        end
      end else if (handshake_c) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_code_decoder.sv
// Directed bench for key_code_decoder with hand-computed expectations.
`timescale 1ns/1ps
module tb_key_code_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] code_n;
  logic [8:0] line_n;
  logic [3:0] key_val;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_key;
  logic       evt_press;
  logic       evt_overrun;
  logic       code_err;

  int n_cmp;
  int n_err;

  key_code_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .code_n      (code_n),
    .line_n      (line_n),
    .key_val     (key_val),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_press   (evt_press),
    .evt_overrun (evt_overrun),
    .code_err    (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report on mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".line_n"},      32'(line_n),      32'h1FF);
    chk({tag, ".key_val"},     32'(key_val),     32'd0);
    chk({tag, ".evt_valid"},   32'(evt_valid),   32'd0);
    chk({tag, ".evt_key"},     32'(evt_key),     32'd0);
    chk({tag, ".evt_press"},   32'(evt_press),   32'd0);
    chk({tag, ".evt_overrun"}, 32'(evt_overrun), 32'd0);
    chk({tag, ".code_err"},    32'(code_err),    32'd0);
  endtask

  task automatic chk_evt(input string tag, input logic [3:0] k, input logic p);
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, ".evt_key"},   32'(evt_key),   32'(k));
    chk({tag, ".evt_press"}, 32'(evt_press), 32'(p));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    code_n    = 4'b1111;
    evt_ready = 1'b1;
    step(2);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // 1: key 1 press, latency 4 edges, consumed next edge
    code_n = 4'b1110;
    step(3);
    chk("t1.early_line", 32'(line_n), 32'h1FF);
    chk("t1.early_valid", 32'(evt_valid), 32'd0);
    step(1);
    chk("t1.line_n", 32'(line_n), 32'h1FE);
    chk("t1.key_val", 32'(key_val), 32'd1);
    chk_evt("t1", 4'd1, 1'b1);
    step(1);
    chk("t1.consumed", 32'(evt_valid), 32'd0);
    step(3);
    chk("t1.no_retrigger", 32'(evt_valid), 32'd0);
    code_n = 4'b1111;
    step(4);
    chk("t1.rel_line", 32'(line_n), 32'h1FF);
    chk_evt("t1.rel", 4'd1, 1'b0);
    step(1);

    // 2: three-edge glitch of key 9 produces nothing
    code_n = 4'b0110;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) code_n = 4'b1111;
      step(1);
      chk("t2.line_n", 32'(line_n), 32'h1FF);
      chk("t2.evt_valid", 32'(evt_valid), 32'd0);
      chk("t2.code_err", 32'(code_err), 32'd0);
    end

    // 3: key 9 held then released
    code_n = 4'b0110;
    step(4);
    chk("t3.line_n", 32'(line_n), 32'h0FF);
    chk("t3.key_val", 32'(key_val), 32'd9);
    chk_evt("t3.press", 4'd9, 1'b1);
    step(1);
    code_n = 4'b1111;
    step(4);
    chk("t3.rel_line", 32'(line_n), 32'h1FF);
    chk("t3.rel_key_val", 32'(key_val), 32'd0);
    chk_evt("t3.rel", 4'd9, 1'b0);
    step(1);

    // 4: invalid code 15 -> one-cycle code_err at the 4th edge only
    code_n = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk($sformatf("t4.code_err%0d", i), 32'(code_err), (i == 4) ? 32'd1 : 32'd0);
      chk("t4.line_n", 32'(line_n), 32'h1FF);
      chk("t4.evt_valid", 32'(evt_valid), 32'd0);
    end
    code_n = 4'b1111;
    step(5);
    chk("t4.idle_valid", 32'(evt_valid), 32'd0);
    chk("t4.idle_line", 32'(line_n), 32'h1FF);

    // 5: consumer stalled: release of key 3 is dropped, overrun sticks
    evt_ready = 1'b0;
    code_n    = 4'b1100;
    step(4);
    chk_evt("t5.press", 4'd3, 1'b1);
    chk("t5.line_n", 32'(line_n), 32'h1FB);
    code_n = 4'b1111;
    step(4);
    chk_evt("t5.kept", 4'd3, 1'b1);
    chk("t5.overrun", 32'(evt_overrun), 32'd1);
    chk("t5.rel_line", 32'(line_n), 32'h1FF);
    chk("t5.rel_key_val", 32'(key_val), 32'd0);
    evt_ready = 1'b1;
    step(1);
    chk("t5.drained", 32'(evt_valid), 32'd0);
    chk("t5.overrun_sticky", 32'(evt_overrun), 32'd1);

    // 6: reset mid-operation with key 5 held and event pending
    evt_ready = 1'b0;
    code_n    = 4'b1010;
    step(4);
    chk("t6.line_n", 32'(line_n), 32'h1EF);
    chk_evt("t6.pending", 4'd5, 1'b1);
    rst_n = 1'b0;
    step(1);
    chk_reset_vals("t6.reset");
    rst_n = 1'b1;
    step(3);
    chk("t6.requal_line", 32'(line_n), 32'h1FF);
    chk("t6.requal_valid", 32'(evt_valid), 32'd0);
    step(1);
    chk("t6.line_n2", 32'(line_n), 32'h1EF);
    chk("t6.key_val", 32'(key_val), 32'd5);
    chk_evt("t6.fresh", 4'd5, 1'b1);

    // 7: HELD 5 -> key 2 gives a press for 2 only
    evt_ready = 1'b1;
    code_n    = 4'b1101;
    step(1);
    chk("t7.consumed", 32'(evt_valid), 32'd0);
    step(3);
    chk("t7.line_n", 32'(line_n), 32'h1FD);
    chk("t7.key_val", 32'(key_val), 32'd2);
    chk_evt("t7.press", 4'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
